// File: rtl/masked_pkg.sv
// Shared constants for the masked AND/OR pipeline: share count and op encoding.
package masked_pkg;

   localparam int   SHARES = 2;
   localparam logic OP_AND = 1'b0;
   localparam logic OP_OR  = 1'b1;

   // Builds without OR support see every operation as AND.
   function automatic logic eff_op(input logic op, input bit or_en);
      return or_en ? op : OP_AND;
   endfunction

endpackage

// File: rtl/masked_and_slice.sv
// One bit lane of the masked AND/OR gadget: stage-1..3 share registers with per-stage enables.
module masked_and_slice
   import masked_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic en1,
   input  logic en2,
   input  logic en3,
   input  logic op_s0,
   input  logic op_s2,
   input  logic a0,
   input  logic a1,
   input  logic b0,
   input  logic b1,
   output logic q0,
   output logic q1
);

   logic a0p, b0p;
   logic t1, t2, t4, m, a1_s1;
   logic r3, r5, a1_s2;

   // OR is computed as AND of inverted operands, then the result is inverted.
   assign a0p = a0 ^ op_s0;
   assign b0p = b0 ^ op_s0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         t1    <= 1'b0;
         t2    <= 1'b0;
         t4    <= 1'b0;
         m     <= 1'b0;
         a1_s1 <= 1'b0;
      end else if (en1) begin
         t1    <= a0p & b0p;
         t2    <= (a0p & b1) ^ b1;
         t4    <= a1 & b0p;
         m     <= a1 | b1;
         a1_s1 <= a1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r3    <= 1'b0;
         r5    <= 1'b0;
         a1_s2 <= 1'b0;
      end else if (en2) begin
         r3    <= t1 ^ t2;
         r5    <= t4 ^ m;
         a1_s2 <= a1_s1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q0 <= 1'b0;
         q1 <= 1'b0;
      end else if (en3) begin
         q0 <= r3 ^ r5 ^ op_s2;
         q1 <= a1_s2;
      end
   end

endmodule

// File: rtl/masked_and_pipe.sv
// Three-stage masked AND/OR on Boolean shares with valid/ready flow control shared by all lanes.
// Handshake: a transfer happens on a posedge where valid & ready; valid never waits on ready.
module masked_and_pipe
   import masked_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter bit OR_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             op,
   input  logic [WIDTH-1:0] a0,
   input  logic [WIDTH-1:0] a1,
   input  logic [WIDTH-1:0] b0,
   input  logic [WIDTH-1:0] b1,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] q0,
   output logic [WIDTH-1:0] q1
);

   logic v1, v2, v3;
   logic load1, load2, load3;
   logic op_s0, op_s2;

   // A stage loads when it is empty or its current contents move on this cycle.
   assign load3     = v2 & (~v3 | out_ready);
   assign load2     = v1 & (~v2 | load3);
   assign in_ready  = ~v1 | load2;
   assign load1     = in_valid & in_ready;
   assign out_valid = v3;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1 <= 1'b0;
         v2 <= 1'b0;
         v3 <= 1'b0;
      end else begin
         v1 <= load1 | (v1 & ~load2);
         v2 <= load2 | (v2 & ~load3);
         v3 <= load3 | (v3 & ~out_ready);
      end
   end

   assign op_s0 = eff_op(op, OR_EN);

   generate
      if (OR_EN) begin : g_op
         logic op_s1;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               op_s1 <= OP_AND;
               op_s2 <= OP_AND;
            end else begin
               if (load1) op_s1 <= op_s0;
               if (load2) op_s2 <= op_s1;
            end
         end
      end else begin : g_no_op
         assign op_s2 = OP_AND;
      end
   endgenerate

   generate
      for (genvar i = 0; i < WIDTH; i++) begin : g_lane
         masked_and_slice u_slice (
            .clk   (clk),
            .rst_n (rst_n),
            .en1   (load1),
            .en2   (load2),
            .en3   (load3),
            .op_s0 (op_s0),
            .op_s2 (op_s2),
            .a0    (a0[i]),
            .a1    (a1[i]),
            .b0    (b0[i]),
            .b1    (b1[i]),
            .q0    (q0[i]),
            .q1    (q1[i])
         );
      end
   endgenerate

endmodule

// File: tb/tb_masked_and_pipe.sv
// Bench for masked_and_pipe: WIDTH=4 main and AND-only instances, WIDTH=1 instance for the sweep.
module tb_masked_and_pipe;

   localparam int W = 4;

   // clock / reset
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic         in_valid = 1'b0, op = 1'b0, out_ready = 1'b1;
   logic [W-1:0] a0 = '0, a1 = '0, b0 = '0, b1 = '0;
   logic         in_ready, out_valid;
   logic [W-1:0] q0, q1;
   logic         and_in_ready, and_out_valid;
   logic [W-1:0] and_q0, and_q1;

   logic s_in_valid = 1'b0, s_op = 1'b0, s_out_ready = 1'b1;
   logic s_a0 = 1'b0, s_a1 = 1'b0, s_b0 = 1'b0, s_b1 = 1'b0;
   logic s_in_ready, s_out_valid, s_q0, s_q1;

   masked_and_pipe #(.WIDTH(W), .OR_EN(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
      .a0(a0), .a1(a1), .b0(b0), .b1(b1), .out_valid(out_valid), .out_ready(out_ready),
      .q0(q0), .q1(q1)
   );

   masked_and_pipe #(.WIDTH(W), .OR_EN(1'b0)) dut_and (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(and_in_ready), .op(op),
      .a0(a0), .a1(a1), .b0(b0), .b1(b1), .out_valid(and_out_valid), .out_ready(out_ready),
      .q0(and_q0), .q1(and_q1)
   );

   masked_and_pipe #(.WIDTH(1), .OR_EN(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready), .op(s_op),
      .a0(s_a0), .a1(s_a1), .b0(s_b0), .b1(s_b1), .out_valid(s_out_valid), .out_ready(s_out_ready),
      .q0(s_q0), .q1(s_q1)
   );

   // scoreboard entry: {and-only result, expected result, expected q1}
   logic [3*W-1:0] exp_q[$];
   int checks = 0;
   int errors = 0;
   int popped = 0;

   function automatic logic [W-1:0] ref_op(input logic o, input logic [W-1:0] x0, x1, y0, y1);
      logic [W-1:0] a, b;
      a = x0 ^ x1;
      b = y0 ^ y1;
      return o ? (a | b) : (a & b);
   endfunction

   // driver: presents inputs after negedge, records an accept that happens at the next posedge
   task automatic drive(input logic v, input logic o, input logic [W-1:0] x0, x1, y0, y1,
                        input logic ordy, output logic acc);
      @(negedge clk);
      in_valid = v; op = o; a0 = x0; a1 = x1; b0 = y0; b1 = y1; out_ready = ordy;
      #1;
      acc = v && in_ready;
      if (acc) exp_q.push_back({ref_op(1'b0, x0, x1, y0, y1), ref_op(o, x0, x1, y0, y1), x1});
   endtask

   task automatic idle(input logic ordy);
      logic acc;
      drive(1'b0, 1'b0, '0, '0, '0, '0, ordy, acc);
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         idle(1'b1);
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d results outstanding, required 0", exp_q.size());
      end
   endtask

   // monitor: compares each handed-off result against the queue head
   always begin : mon
      logic [3*W-1:0] e;
      @(negedge clk);
      #2;
      if (rst_n) begin
         checks++;
         if (and_out_valid !== out_valid) begin
            errors++;
            $display("FAIL and_valid: got %b required %b", and_out_valid, out_valid);
         end
         if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_output: q0=%h q1=%h with empty scoreboard", q0, q1);
            end else begin
               e = exp_q.pop_front();
               popped++;
               if ((q0 ^ q1) !== e[2*W-1:W]) begin
                  errors++;
                  $display("FAIL result: q0^q1=%h required %h", q0 ^ q1, e[2*W-1:W]);
               end
               checks++;
               if (q1 !== e[W-1:0]) begin
                  errors++;
                  $display("FAIL q1: got %h required %h", q1, e[W-1:0]);
               end
               checks++;
               if ((and_q0 ^ and_q1) !== e[3*W-1:2*W] || and_q1 !== e[W-1:0]) begin
                  errors++;
                  $display("FAIL and_only: q0^q1=%h q1=%h required %h %h",
                           and_q0 ^ and_q1, and_q1, e[3*W-1:2*W], e[W-1:0]);
               end
            end
         end
      end
   end

   task automatic test_reset();
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || q0 !== '0 || q1 !== '0) begin
         errors++;
         $display("FAIL reset_state: in_ready=%b out_valid=%b q0=%h q1=%h required 1 0 0 0",
                  in_ready, out_valid, q0, q1);
      end
      checks++;
      if (s_in_ready !== 1'b1 || s_out_valid !== 1'b0 || and_out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_other: s_in_ready=%b s_out_valid=%b and_out_valid=%b required 1 0 0",
                  s_in_ready, s_out_valid, and_out_valid);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_directed(input logic o, input logic [W-1:0] exp_q0);
      logic acc;
      int cycles;
      drive(1'b1, o, 4'b1010, 4'b0110, 4'b0011, 4'b1001, 1'b1, acc);
      checks++;
      if (acc !== 1'b1) begin
         errors++;
         $display("FAIL directed_accept: op=%b accepted=%b required 1", o, acc);
      end
      idle(1'b1);
      cycles = 1;
      while (!out_valid && cycles < 10) begin
         idle(1'b1);
         cycles++;
      end
      checks++;
      if (cycles !== 3) begin
         errors++;
         $display("FAIL latency: op=%b got %0d cycles required 3", o, cycles);
      end
      checks++;
      if (q0 !== exp_q0 || q1 !== 4'b0110) begin
         errors++;
         $display("FAIL directed: op=%b q0=%b q1=%b required q0=%b q1=0110", o, q0, q1, exp_q0);
      end
      drain(10);
   endtask

   task automatic test_back_to_back();
      logic acc;
      int stalls = 0, gaps = 0, start = popped;
      for (int i = 0; i < 1000; i++) begin
         drive(1'b1, 1'($urandom_range(0, 1)), W'($urandom), W'($urandom), W'($urandom),
               W'($urandom), 1'b1, acc);
         if (!acc) stalls++;
         if (i >= 3 && !out_valid) gaps++;
      end
      drain(10);
      checks++;
      if (stalls != 0 || gaps != 0) begin
         errors++;
         $display("FAIL throughput: stalls=%0d gaps=%0d required 0 0", stalls, gaps);
      end
      checks++;
      if (popped - start != 1000) begin
         errors++;
         $display("FAIL stream_count: got %0d results required 1000", popped - start);
      end
   endtask

   task automatic test_stall();
      logic acc;
      logic [W-1:0] x0, x1, y0, y1, snap0, snap1;
      logic o;
      int accepts = 0, tries = 0, bad = 0, start = popped;
      do begin
         o = 1'($urandom_range(0, 1));
         x0 = W'($urandom); x1 = W'($urandom); y0 = W'($urandom); y1 = W'($urandom);
         drive(1'b1, o, x0, x1, y0, y1, 1'b0, acc);
         if (acc) accepts++;
         tries++;
      end while (acc && tries < 10);
      checks++;
      if (accepts != 3) begin
         errors++;
         $display("FAIL stall_capacity: accepted %0d before in_ready=0, required 3", accepts);
      end
      snap0 = q0;
      snap1 = q1;
      for (int k = 0; k < 5; k++) begin
         drive(1'b1, o, x0, x1, y0, y1, 1'b0, acc);
         if (acc || !out_valid || q0 !== snap0 || q1 !== snap1) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL stall_hold: %0d unstable cycles required 0", bad);
      end
      drive(1'b1, o, x0, x1, y0, y1, 1'b1, acc);
      checks++;
      if (acc !== 1'b1) begin
         errors++;
         $display("FAIL release_accept: accepted=%b required 1", acc);
      end
      drain(10);
      checks++;
      if (popped - start != 4) begin
         errors++;
         $display("FAIL stall_count: got %0d results required 4", popped - start);
      end
   endtask

   task automatic test_reset_flight();
      logic acc;
      int stale = 0;
      for (int i = 0; i < 3; i++)
         drive(1'b1, 1'($urandom_range(0, 1)), W'($urandom), W'($urandom), W'($urandom),
               W'($urandom), 1'b1, acc);
      @(negedge clk);
      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      exp_q.delete();
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || q0 !== '0 || q1 !== '0) begin
         errors++;
         $display("FAIL reset_flight: out_valid=%b in_ready=%b q0=%h q1=%h required 0 1 0 0",
                  out_valid, in_ready, q0, q1);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         idle(1'b1);
         if (out_valid) stale++;
      end
      checks++;
      if (stale != 0) begin
         errors++;
         $display("FAIL stale_output: %0d cycles with out_valid after reset, required 0", stale);
      end
      test_directed(1'b0, 4'b1110);
   endtask

   task automatic test_exhaustive();
      logic ea, eb, er;
      int cnt;
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         s_in_valid = 1'b1;
         s_a0 = i[0]; s_a1 = i[1]; s_b0 = i[2]; s_b1 = i[3]; s_op = i[4];
         ea = i[0] ^ i[1];
         eb = i[2] ^ i[3];
         er = i[4] ? (ea | eb) : (ea & eb);
         @(negedge clk);
         s_in_valid = 1'b0;
         cnt = 0;
         while (!s_out_valid && cnt < 5) begin
            @(negedge clk);
            cnt++;
         end
         #1;
         checks++;
         if (s_out_valid !== 1'b1) begin
            errors++;
            $display("FAIL sweep_valid: combo %0d out_valid=%b required 1", i, s_out_valid);
         end
         checks++;
         if ((s_q0 ^ s_q1) !== er) begin
            errors++;
            $display("FAIL sweep_result: combo %0d q0^q1=%b required %b", i, s_q0 ^ s_q1, er);
         end
         checks++;
         if (s_q1 !== i[1]) begin
            errors++;
            $display("FAIL sweep_q1: combo %0d q1=%b required %b", i, s_q1, i[1]);
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_directed(1'b0, 4'b1110);
      test_directed(1'b1, 4'b1000);
      test_back_to_back();
      test_stall();
      test_reset_flight();
      test_exhaustive();
      idle(1'b1);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL final_queue: %0d results outstanding, required 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/masked_and_pipe.md
MASKED_AND_PIPE -- requirements
Module: masked_and_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8: number of independent masked bit lanes (1..64).
REQ-002 SHALL have parameter OR_EN, default 1: 1 = op input honoured; 0 = op ignored, AND only.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on posedge.
REQ-004 SHALL have port rst_n  input  1: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1: operand shares and op present.
REQ-006 SHALL have port in_ready  output  1: operands accepted this cycle when in_valid & in_ready.
REQ-007 SHALL have port op  input  1: 0 = AND, 1 = OR; travels with its operands.
REQ-008 SHALL have ports a0, a1, b0, b1  input  WIDTH: Boolean shares; a = a0^a1, b = b0^b1.
REQ-009 SHALL have port out_valid  output  1: q0/q1 hold a result.
REQ-010 SHALL have port out_ready  input  1: downstream takes the result when out_valid & out_ready.
REQ-011 SHALL have ports q0, q1  output  WIDTH: result shares; q0^q1 = a&b (op=0) or a|b (op=1).

Function
REQ-012 SHALL use no fresh randomness; q1 SHALL equal the accepted a1, delayed to align with q0.
REQ-013 Stage 1 SHALL register per lane t1=a0'&b0', t2=(a0'&b1)^b1, t4=a1&b0', m=a1|b1, a1 and op, where a0'=a0^op and b0'=b0^op.
REQ-014 Stage 2 SHALL register r3=t1^t2 and r5=t4^m, and SHALL carry a1 and op forward.
REQ-015 Stage 3 SHALL register q0=r3^r5^op and q1=a1.
REQ-016 Every recombination SHALL consume only register outputs; no combinational path from a0/a1/b0/b1 to q0/q1.
REQ-017 Latency SHALL be exactly 3 cycles from acceptance to out_valid when the pipeline is not stalled.
REQ-018 Each stage SHALL have its own valid bit and SHALL load when empty or when its contents move on in the same cycle.
REQ-019 in_ready SHALL equal (!v1 | stage-1 advance); sustained throughput SHALL be 1 result/cycle with out_ready=1.
REQ-020 When out_valid=1 and out_ready=0, q0, q1 and out_valid SHALL hold; upstream stages SHALL fill bubbles, then stall.
REQ-021 Data registers of a stage that does not load SHALL hold their value; share registers SHALL NOT be cleared or overwritten mid-stall.
REQ-022 Simultaneous accept and output handoff with all stages full SHALL advance every stage in one cycle with no loss or duplication.
REQ-023 With OR_EN=0, op SHALL be treated as 0 and stage op registers SHALL be absent.

Reset
REQ-024 Asserting rst_n low SHALL immediately clear v1, v2, v3 and out_valid, and SHALL drive in_ready=1 and q0=q1=0.
REQ-025 All data registers SHALL reset to 0.
REQ-026 Reset mid-operation SHALL discard all in-flight results; the first accept after release SHALL produce the next out_valid.

Structure
REQ-027 Package masked_pkg SHALL hold SHARES=2 and the op encoding constants OP_AND=0, OP_OR=1.
REQ-028 One bit-lane sub-module masked_and_slice SHALL hold the per-lane stage-1..3 data registers with per-stage enables; it SHALL be instantiated WIDTH times.
REQ-029 Valid and stall control SHALL sit once in masked_and_pipe and be shared by all lanes.

Verification
REQ-030 WIDTH=4, op=0, a0=1010, a1=0110, b0=0011, b1=1001, out_ready=1 -> 3 cycles later out_valid=1, q1=0110, q0=1110 (q0^q1=1000).
REQ-031 Same operands with op=1 -> q1=0110, q0=1000 (q0^q1=1110).
REQ-032 Random operands on every cycle, out_ready=1, 1000 transactions -> q0^q1 matches the reference model, one result per cycle, order preserved.
REQ-033 Fill the pipeline, hold out_ready=0 for 5 cycles -> in_ready=0 after 3 more accepts, outputs stable; release -> all 4 results delivered in order.
REQ-034 rst_n low for 1 cycle with 3 results in flight -> out_valid=0 at once; no stale result appears afterwards.
REQ-035 Exhaustive WIDTH=1 sweep of all 32 (a0,a1,b0,b1,op) combinations -> q0^q1 correct and q1=a1 for each.
